// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: decode/CP0 control in, instruction-memory bus, and the IF/ID register out.
interface ifu_fetch_if;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        exc_req;
   logic        eret_en;
   logic [31:0] epc;
   logic [31:0] im_addr;
   logic [31:0] im_rd;
   logic [31:0] f_pc;
   logic [31:0] d_instr;
   logic [31:0] d_pc;
   logic        d_valid;
   logic [4:0]  d_exccode;

   modport master (
      input  stall, redirect_en, redirect_pc, exc_req, eret_en, epc, im_rd,
      output im_addr, f_pc, d_instr, d_pc, d_valid, d_exccode
   );

   modport slave (
      output stall, redirect_en, redirect_pc, exc_req, eret_en, epc, im_rd,
      input  im_addr, f_pc, d_instr, d_pc, d_valid, d_exccode
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, drives instruction memory and fills the IF/ID slot,
// tagging out-of-range or misaligned fetches with AdEL so they never reach D as real words.
module ifu_fetch #(
   parameter logic [31:0] PC_RESET  = 32'h0000_3000,
   parameter logic [31:0] IM_BASE   = 32'h0000_3000,
   parameter int          IM_WORDS  = 4096,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
   input logic         clk,
   input logic         reset,
   ifu_fetch_if.master bus
);
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic [4:0]  exccode;
   } slot_t;

   // 33-bit bound so a window ending at 2^32 cannot wrap
   localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

   logic [31:0] pc;
   slot_t       slot;
   logic        fault;
   logic [31:0] fetch_word;

   assign fault      = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_LIMIT);
   assign fetch_word = fault ? 32'h0 : bus.im_rd;

   assign bus.im_addr   = pc;
   assign bus.f_pc      = pc;
   assign bus.d_instr   = slot.instr;
   assign bus.d_pc      = slot.pc;
   assign bus.d_valid   = slot.valid;
   assign bus.d_exccode = slot.exccode;

   // exc/eret flush the slot; redirect keeps it (delay slot) and is dropped under stall
   always_ff @(posedge clk) begin
      if (reset) begin
         pc   <= PC_RESET;
         slot <= '0;
      end else if (bus.exc_req) begin
         pc   <= EXC_ENTRY;
         slot <= '0;
      end else if (bus.eret_en) begin
         pc   <= bus.epc;
         slot <= '0;
      end else if (!bus.stall) begin
         pc   <= bus.redirect_en ? bus.redirect_pc : pc + 32'd4;
         slot <= '{instr: fetch_word, pc: pc, valid: 1'b1,
                   exccode: fault ? EXC_ADEL : 5'd0};
      end
   end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch initiator that drives the byte address into the instruction memory and captures the returned word into the IF/ID pipeline register.
- Holds the architectural PC and advances it sequentially.
- Applies stall, branch/jump redirect, exception entry and eret return to the PC.
- Flags fetch address faults (AdEL) so the downstream stages never consume an out-of-range word.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, byte address of instruction memory word 0.
- IM_WORDS, 4096, instruction memory depth in words; valid fetch range is IM_BASE to IM_BASE+4*IM_WORDS-1.
- EXC_ENTRY, 32'h0000_4180, handler entry PC.
- EXC_ADEL, 5'd4, ExcCode reported for a fetch fault.

Ports:
- clk input 1: system clock; all state updates on rising edge.
- reset input 1: synchronous, active-high.
- stall input 1: hazard stall from decode; freezes PC and IF/ID.
- redirect_en input 1: branch/jump taken, resolved in D.
- redirect_pc input 32: target PC for redirect_en.
- exc_req input 1: exception/interrupt taken (from CP0).
- eret_en input 1: eret committing.
- epc input 32: return PC for eret_en.
- im_addr output 32: byte address to instruction memory; equals pc.
- im_rd input 32: combinational instruction word returned for im_addr.
- f_pc output 32: current fetch PC, for debug and CP0 EPC.
- d_instr output 32: IF/ID instruction.
- d_pc output 32: IF/ID PC.
- d_valid output 1: IF/ID holds a real fetched slot.
- d_exccode output 5: 0 = none, EXC_ADEL = fetch fault.

Behaviour:
- State: pc (32-bit) plus the IF/ID register {d_instr, d_pc, d_valid, d_exccode}.
- im_addr and f_pc are combinational copies of pc.
- Fetch fault (combinational) fires when any of these hold:
  - pc[1:0] != 0;
  - pc < IM_BASE;
  - pc >= IM_BASE + 4*IM_WORDS.
  - Comparisons are unsigned 32-bit; the upper bound is computed in 33 bits so it cannot overflow.
- Fetched word: 32'h0 (nop) when the fetch fault fires, else im_rd.
- Reset values: pc = PC_RESET; d_instr = 0; d_pc = 0; d_valid = 0; d_exccode = 0.
- PC next-state priority (highest first):
  1. reset → PC_RESET.
  2. exc_req → EXC_ENTRY.
  3. eret_en → epc.
  4. stall → hold pc.
  5. redirect_en → redirect_pc.
  6. otherwise → pc + 4, wrapping modulo 2^32.
- IF/ID next-state priority (highest first):
  1. reset, exc_req or eret_en → clear to reset values. This flushes the slot; there is no delay slot after eret.
  2. stall → hold all fields.
  3. otherwise → d_instr = fetched word, d_pc = pc, d_valid = 1, d_exccode = EXC_ADEL if the fetch fault fired, else 0.
- Delay slot: redirect_en does not flush IF/ID. The instruction fetched in the same cycle as redirect_en (the delay slot) enters D normally.
- redirect_en while stall = 1 is ignored. Decode must hold redirect_en until stall drops.
- exc_req and eret_en asserted together: exc_req wins.
- Latency: the word at pc appears on d_instr one cycle after that pc is presented.
- Faulting slots still advance the PC; CP0 raises exc_req when the slot reaches the commit point.
- reset mid-operation: everything returns to reset values on the next edge regardless of the other inputs.

Test Plan:
- Reset, then 4 free-running cycles with memory holding 0x11111111, 0x22222222, 0x33333333 at 0x3000/0x3004/0x3008 → d_pc = 0x3000, 0x3004, 0x3008 on successive cycles; d_instr matches; d_valid = 1; d_exccode = 0.
- stall = 1 for 3 cycles at pc = 0x3008 → pc and every IF/ID field frozen; after release, d_pc = 0x3008 then 0x300C.
- redirect_en = 1, redirect_pc = 0x3100 in the cycle pc = 0x3010 → next d_pc = 0x3010 (delay slot), then 0x3100. Repeat with stall = 1 on the same cycle → redirect ignored, pc holds 0x3010.
- redirect_pc = 0x3102 → d_instr = 0, d_exccode = 4, d_valid = 1. Repeat with redirect_pc = 0x0000_2FFC and with 0x0000_7000 (IM_WORDS = 4096) → same response.
- exc_req and eret_en both = 1, epc = 0x3050 → pc = 0x4180 and IF/ID cleared. Next, eret_en alone → pc = 0x3050, d_valid = 0 for one cycle.
- Drive redirect_en = 1 and stall = 1 while pulsing reset → pc = 0x3000, d_valid = 0; normal fetch resumes on the following cycle.
